// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: the access-size type plus the byte-enable,
// alignment and misalignment helpers. The CPU-side buffer and the memory
// responder both use these helpers.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    // Lane mask for an access of 'size' starting at byte offset 'adr'.
    // The result covers up to 8 lanes.
    function automatic logic [7:0] biu_size2be(input biu_size_t size, input logic [2:0] adr);
        logic [7:0] base;
        case (size)
            BYTE:    base = 8'h01;
            HWORD:   base = 8'h03;
            WORD:    base = 8'h0f;
            DWORD:   base = 8'hff;
            default: base = 8'h00;
        endcase
        return base << adr;
    endfunction

    // Returns 1 when the offset is not a multiple of the access size.
    // Unknown sizes are always reported as misaligned.
    function automatic logic biu_misaligned(input biu_size_t size, input logic [2:0] adr);
        logic mis;
        case (size)
            BYTE:    mis = 1'b0;
            HWORD:   mis = adr[0];
            WORD:    mis = |adr[1:0];
            DWORD:   mis = |adr;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Clears the offset bits that lie below the access size (natural alignment).
    function automatic logic [2:0] biu_align(input biu_size_t size, input logic [2:0] adr);
        logic [2:0] a;
        case (size)
            HWORD:   a = {adr[2:1], 1'b0};
            WORD:    a = {adr[2], 2'b00};
            DWORD:   a = 3'b000;
            default: a = adr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/riscv_memrsp_pipe.sv
// Response shift pipeline with STAGES stages. Each stage carries a valid bit
// and a W-bit payload. The pipeline advances only when ena_i is high.
// clr_i clears every valid bit but leaves the payloads in place.
module riscv_memrsp_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ena_i,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0]        vld_pipe;
    logic [STAGES-1:0][W-1:0] dat_pipe;

    // Shift on enable. A clear drops all in-flight valids. Reset also zeroes
    // the payloads so that q reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            if (ena_i) begin
                vld_pipe[0] <= vld_i;
                dat_pipe[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
            if (clr_i) vld_pipe <= '0;
        end
    end

    assign vld_o = vld_pipe[STAGES-1];
    assign q_o   = dat_pipe[STAGES-1];

endmodule

// File: rtl/riscv_memrsp.sv
// Memory responder: a word array behind the CPU memory interface. It gives
// in-order acks after LATENCY enabled cycles.
// Optional macro RISCV_MEMRSP_ERR_EN:
//   - adds err_o;
//   - flags misaligned or illegal accesses;
//   - suppresses their writes.
// Without the macro:
//   - addresses are naturally aligned;
//   - an oversized access is clamped to the widest legal size.
module riscv_memrsp
    import biu_constants_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ABITS   = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            ena_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            lock_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    output logic            ack_o,
    output logic [XLEN-1:0] q_o
`ifdef RISCV_MEMRSP_ERR_EN
   ,output logic            err_o
`endif
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] q;
    } entry_t;

    logic [XLEN-1:0]  mem [2**ABITS];
    logic             accept;
    logic [ABITS-1:0] widx;
    logic [2:0]       off_raw, off;
    biu_size_t        size_eff;
    logic             bad;
    logic [7:0]       be8;
    logic [NB-1:0]    be;
    entry_t           rsp, last;
    logic             last_vld;
    logic             unused_ok;

    assign accept = req_i & ena_i & ~clr_i;
    assign widx   = adr_i[ABITS+LB-1:LB];

    // Decode the access: effective size, lane offset, error flag, lane mask
    // and the response entry. Reads sample the word as it is before this edge.
    always_comb begin
        off_raw         = '0;
        off_raw[LB-1:0] = adr_i[LB-1:0];
`ifdef RISCV_MEMRSP_ERR_EN
        size_eff = size_i;
        off      = off_raw;
        bad      = biu_misaligned(size_i, off_raw) | ((size_i == DWORD) && (XLEN == 32));
`else
        size_eff = size_i;
        if ((size_i == QWORD) || ((size_i == DWORD) && (XLEN == 32))) begin
            if (XLEN == 64) size_eff = DWORD;
            else            size_eff = WORD;
        end
        off = biu_align(size_eff, off_raw);
        bad = 1'b0;
`endif
        be8    = biu_size2be(size_eff, off);
        be     = be8[NB-1:0];
        rsp.err = bad;
        rsp.q   = (we_i | bad) ? '0 : mem[widx];
    end

    // Byte-lane write at the accept edge. An access that errors never writes.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !bad) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= d_i[8*k +: 8];
            end
        end
    end

    riscv_memrsp_pipe #(
        .W      ($bits(entry_t)),
        .STAGES (LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ena_i  (ena_i),
        .clr_i  (clr_i),
        .vld_i  (accept),
        .d_i    (rsp),
        .vld_o  (last_vld),
        .q_o    (last)
    );

    assign ack_o = last_vld & ena_i;
    assign q_o   = last.q;
`ifdef RISCV_MEMRSP_ERR_EN
    assign err_o = last.err;
`endif

    // lock_i is accepted and ignored: there is one target and no arbitration.
    assign unused_ok = ^{lock_i, adr_i[XLEN-1:ABITS+LB], be8, last.err};

endmodule

// File: doc/riscv_memrsp.md
# riscv_memrsp

Memory-system-side responder for the CPU memory access interface (req/adr/size/lock/we/d in, ack/q out). It accepts one request per enabled cycle and performs the write or read on an internal word array. It returns an in-order acknowledge with read data after a fixed, parameterised latency. It serves as the target behind the CPU memory buffer in core-level simulation and small on-chip TCM configurations.

## Interface
- XLEN, 32: data/address width; 32 or 64.
- ABITS, 10: word-address bits; the array holds 2^ABITS words of XLEN bits.
- LATENCY, 2: cycles from request accept to ack_o; legal range 1..8.
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- clr_i  input  1  flush all in-flight responses.
- ena_i  input  1  pipeline enable; low freezes the block.
- req_i  input  1  access request.
- adr_i  input  XLEN  byte address.
- size_i  input  biu_size_t  access size (BYTE/HWORD/WORD/DWORD).
- lock_i  input  1  locked access; accepted and ignored (single target, no arbitration).
- we_i  input  1  1=write, 0=read.
- d_i  input  XLEN  write data, lane-aligned (byte k of the access in lane adr_i[..]+k).
- ack_o  output  XLEN-independent 1  response strobe, one per accepted request, in order.
- q_o  output  XLEN  read data (full aligned word); 0 for writes.
- err_o  output  1  access error (only with RISCV_MEMRSP_ERR_EN).

## Operation
- Accept: req_i & ena_i & ~clr_i; there is no back-pressure, and every such request is accepted.
- Word index: adr_i[ABITS+LB-1:LB], where LB = log2(XLEN/8). Addresses wrap modulo the array size.
- Byte enables:
  - BYTE: 1 lane at adr_i[LB-1:0].
  - HWORD: 2 lanes.
  - WORD: 4 lanes.
  - DWORD: 8 lanes, legal only when XLEN=64.
- Write: the enabled lanes of the array word are updated with d_i at the accept edge.
- Read: the full word is sampled at the accept edge.
- Each accepted request pushes an entry {valid, err, q} into a LATENCY-deep shift pipeline. Entries advance one stage per ena_i cycle.
- ack_o = last-stage valid & ena_i. q_o and err_o are taken from the last stage.
- clr_i clears all valid bits on the next edge. Array contents are kept. A request presented in the same cycle as clr_i is dropped.
- Reset (rst_ni=0 at an edge): all valid bits cleared; ack_o=0, q_o=0, err_o=0. Array contents are not reset and are undefined after power-up.
- A reset or clr_i mid-operation discards in-flight acks. A write already applied to the array stays applied.

## Timing
- A request accepted at edge t gives ack_o high in cycle t+LATENCY, with q_o valid in the same cycle.
- Back-to-back requests give back-to-back acks with no bubble. The maximum in flight is LATENCY.
- Read-after-write:
  - A read accepted one or more cycles after a write sees the new data.
  - There is no same-cycle hazard, because at most one request is accepted per cycle.
- ena_i low:
  - No accept.
  - ack_o forced 0.
  - The pipeline holds; the pending ack appears on the first cycle ena_i returns high.
- Between acks, q_o holds the last-stage value. The bench checks q_o only when ack_o=1.

## Configuration
- RISCV_MEMRSP_ERR_EN defined:
  - err_o port present.
  - A misaligned access (address not a multiple of the size) or DWORD with XLEN=32 is acked normally with err_o=1 and q_o=0.
  - The write of an erroring access is suppressed.
- Undefined:
  - No err_o port.
  - Address low bits below the access size are forced to zero (natural alignment).
  - An illegal DWORD is treated as WORD.

## Structure
- biu_constants_pkg already provides biu_size_t.
- Add a size-to-byte-enable function and a misalignment-check function to biu_constants_pkg, so the CPU-side buffer and the responder share them.
- The pipeline-entry struct depends on XLEN and stays local to the module.
- One sub-module: riscv_memrsp_pipe, a parameterised LATENCY-stage shift pipeline with valid, enable and clear.

## Test plan
- Write then read: write WORD 0xDEADBEEF to 0x40, then read 0x40. With LATENCY=2, acks arrive at t+2 and t+3; the read ack gives q_o=0xDEADBEEF.
- Byte lanes: preload 0x11223344, then write BYTE 0xAA at 0x41 (d_i=0x0000AA00). A read returns 0x1122AA44.
- Streaming: 6 consecutive reads with ena_i=1 produce 6 consecutive ack_o cycles with no gaps.
- Stall and flush:
  - Drop ena_i for 3 cycles with 2 requests in flight; acks resume on re-enable.
  - Pulse clr_i with 2 requests in flight; zero acks follow.
- Reset mid-operation: assert rst_ni=0 for one edge with acks pending. ack_o stays 0 thereafter, and array data written before the reset still reads back.
- ERR_EN build: a HWORD write at 0x43 acks with err_o=1, and the target word is unchanged.
